ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Target-side model of the RAM device on the mobo bus.
- Answers the mobo's four-phase request/acknowledge protocol: RAM_READ_PIN/RAM_WRITE_PIN on ram_ctrl, RAM_ACK on ram_stat.
- Performs word accesses into an internal array after a fixed, parameterized access latency.
- Sits between the mobo ram_ctrl/ram_stat/addr/data_out/data_in nets and stands in for the physical RAM chip.

Parameters:
- DEPTH, 4096, number of 32-bit words; valid addresses are 0..DEPTH-1.
- LATENCY, 2, cycles from request acceptance to ACK rising; legal range 1..255.

Ports:
- clk  in  1  system clock, all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- ram_ctrl  in  32  request pins from mobo; bit RAM_READ_PIN (0) = read request, bit RAM_WRITE_PIN (1) = write request, other bits ignored.
- ram_stat  out  32  status to mobo; bit RAM_ACK (0), bit RAM_BUSY (1), bit RAM_ERR (2), other bits 0.
- addr  in  32  word address from mobo.
- data_in  in  32  write data from mobo (mobo data_out).
- data_out  out  32  read data to mobo (mobo data_in).

Behaviour:
- Reset (rst low, asynchronous): state IDLE; ram_stat = 0, data_out = 0, latency counter = 0. Memory contents are not cleared.
- All outputs are registered. There is no combinational path from inputs to outputs.
- State IDLE:
  - Sampling READ or WRITE high at an edge latches addr, data_in and the op, loads the counter with LATENCY-1, sets BUSY, and goes to ACCESS.
  - Both pins low: stay in IDLE.
- State ACCESS:
  - Counter decrements each edge.
  - At the edge where the counter is 0: perform the access, set ACK, clear BUSY, go to HOLD.
  - ACK is therefore first visible exactly LATENCY cycles after the accepting edge.
  - Write: mem[latched addr] <= latched data at that same edge.
  - Read: data_out <= mem[latched addr] at that same edge.
- State HOLD:
  - ACK and data_out are held stable while either request pin is high.
  - At the first edge with both pins low: ACK <= 0, ERR <= 0, data_out <= 0, go to IDLE.
  - A new request is accepted only from IDLE, so at least one cycle always separates ACK falling from the next BUSY.
- Error cases (access is suppressed, ACK still completes the handshake with ERR = 1):
  - READ and WRITE both high at acceptance: no write, data_out = 0.
  - Latched addr >= DEPTH (full 32-bit compare, no wrap-around): no write, read data_out = 0.
- Request dropped during ACCESS (abort): the access still completes and a write still commits. ACK rises for one cycle, then HOLD sees the pins low and clears ACK.
- Changes on addr or data_in after acceptance are ignored; the latched copies are used.
- Counter width is 8 bits.

Decomposition:
- Shared header control_pins.v gains the pin indices RAM_READ_PIN = 0, RAM_WRITE_PIN = 1, RAM_ACK = 0, RAM_BUSY = 1, RAM_ERR = 2.
- New header ram_states.v holds the encodings RS_IDLE = 0, RS_ACCESS = 1, RS_HOLD = 2, 32-bit wide as in mobo_states.v.
- One sub-module, ram_core: single-port array of DEPTH x 32, synchronous write enable, registered read, no reset. ram_responder owns the FSM, latching, error logic and status.

Test Plan:
1. Write, then read back: assert WRITE with addr = 5, data_in = 0x0000_0A5A; ACK rises 2 cycles after acceptance; drop WRITE; ACK falls next edge. Then READ addr = 5 -> data_out = 0x0000_0A5A while ACK is high, and 0 after ACK falls.
2. Latency and BUSY timing with LATENCY = 4: READ accepted at edge N -> BUSY high from N to N+3, ACK high at N+4, ram_stat = 0x1 in HOLD. Repeat with LATENCY = 1 -> ACK at N+1.
3. Both READ and WRITE high, addr = 3, data_in = 0xFFFF_FFFF -> ACK with ERR (ram_stat = 0x5), data_out = 0. A subsequent read of addr 3 returns the prior value unchanged.
4. Out of range: WRITE addr = DEPTH (4096) -> ram_stat = 0x5, no array write. READ addr = 0xFFFF_FFFF -> ERR set, data_out = 0. READ addr = 4095 -> no ERR.
5. Abort and reset: WRITE addr = 7 dropped one cycle after acceptance -> mem[7] is still written, ACK is high for exactly one cycle. Separately, pulse rst low mid-ACCESS -> ram_stat = 0 and data_out = 0 immediately without waiting for a clock edge, state is IDLE, and the next request is served normally.
6. Mobo-style loop: 20 back-to-back write/read pairs at addr = data = i (0..19) -> every read returns i, with ACK rising only while a request pin is high.

Source files
------------

// File: rtl/ram_responder_pkg.sv
// Shared definitions for the RAM responder slice.
//   - Mobo pin indices on ram_ctrl (requests) and ram_stat (status).
//   - Responder state encodings, 32 bits wide like the other mobo state headers.
//   - req_t: the request copy latched at acceptance.
//   - pack_stat(): assembles the ram_stat word from the status flags.
package ram_responder_pkg;

  localparam int unsigned RAM_READ_PIN  = 0;
  localparam int unsigned RAM_WRITE_PIN = 1;
  localparam int unsigned RAM_ACK       = 0;
  localparam int unsigned RAM_BUSY      = 1;
  localparam int unsigned RAM_ERR       = 2;

  localparam logic [31:0] RS_IDLE   = 32'd0;
  localparam logic [31:0] RS_ACCESS = 32'd1;
  localparam logic [31:0] RS_HOLD   = 32'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;   // clean write (WRITE high, READ low)
    logic        err;  // both pins high or address out of range
  } req_t;

  function automatic logic [31:0] pack_stat(input logic ack, input logic busy,
                                            input logic err);
    logic [31:0] s;
    s           = '0;
    s[RAM_ACK]  = ack;
    s[RAM_BUSY] = busy;
    s[RAM_ERR]  = err;
    return s;
  endfunction

endpackage

// File: rtl/ram_responder_if.sv
// Mobo <-> RAM bus bundle.
//   ram_ctrl : request pins driven by the mobo (READ bit 0, WRITE bit 1)
//   ram_stat : status from the RAM (ACK bit 0, BUSY bit 1, ERR bit 2)
//   addr     : word address from the mobo
//   data_in  : write data from the mobo (mobo data_out)
//   data_out : read data to the mobo (mobo data_in)
// master = mobo side, slave = RAM side.
interface ram_responder_if;
  logic [31:0] ram_ctrl;
  logic [31:0] ram_stat;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output ram_ctrl, output addr, output data_in,
                  input  ram_stat, input  data_out);
  modport slave  (input  ram_ctrl, input  addr, input  data_in,
                  output ram_stat, output data_out);
endinterface

// File: rtl/ram_core.sv
// Single-port DEPTH x 32 word array: synchronous write, registered read,
// no reset (contents survive the responder's reset).
//   clk   : clock
//   we    : write enable, mem[addr] <= wdata on the rising edge
//   addr  : word index
//   wdata : write data
//   rdata : mem[addr] as sampled on the previous rising edge
module ram_core #(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Target-side RAM model on the mobo bus. Answers the four-phase READ/WRITE
// vs ACK handshake, performing the word access LATENCY cycles after a
// request is accepted. Illegal requests (both pins, address >= DEPTH)
// complete the handshake with ERR set and no memory side effect.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : slave side of ram_responder_if (ram_ctrl/addr/data_in in,
//         ram_stat/data_out out, all outputs registered)
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  ram_responder_if.slave  bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

  logic [31:0] state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [31:0] data_out_q, data_out_d;

  logic        rd_pin, wr_pin, any_pin;
  logic        core_we;
  logic [31:0] core_rdata;

  assign rd_pin  = bus.ram_ctrl[RAM_READ_PIN];
  assign wr_pin  = bus.ram_ctrl[RAM_WRITE_PIN];
  assign any_pin = rd_pin | wr_pin;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    ack_d      = ack_q;
    busy_d     = busy_q;
    err_d      = err_q;
    data_out_d = data_out_q;
    core_we    = 1'b0;
    case (state_q)
      RS_IDLE: begin
        if (any_pin) begin
          req_d.addr = bus.addr;
          req_d.data = bus.data_in;
          req_d.wr   = wr_pin & ~rd_pin;
          req_d.err  = (rd_pin & wr_pin) | (bus.addr >= 32'(DEPTH));
          cnt_d      = CNT_LOAD;
          busy_d     = 1'b1;
          state_d    = RS_ACCESS;
        end
      end
      RS_ACCESS: begin
        if (cnt_q == 8'd0) begin
          core_we    = req_q.wr & ~req_q.err;
          // The core address has tracked the latched address since the
          // accepting edge, so its registered read is already valid here.
          data_out_d = (req_q.wr | req_q.err) ? '0 : core_rdata;
          ack_d      = 1'b1;
          busy_d     = 1'b0;
          err_d      = req_q.err;
          state_d    = RS_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RS_HOLD: begin
        if (!any_pin) begin
          ack_d      = 1'b0;
          err_d      = 1'b0;
          data_out_d = '0;
          state_d    = RS_IDLE;
        end
      end
      default: state_d = RS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RS_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
    end
  end

  // Addressed from req_d so the read is launched on the accepting edge;
  // out-of-range addresses alias here but are masked by err.
  ram_core #(.DEPTH(DEPTH)) u_core (
    .clk   (clk),
    .we    (core_we),
    .addr  (req_d.addr[AW-1:0]),
    .wdata (req_q.data),
    .rdata (core_rdata)
  );

  assign bus.ram_stat = pack_stat(ack_q, busy_q, err_q);
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: three instances (LATENCY 2, 4, 1) share one
// mobo-side stimulus. A timestamp/transaction model predicts ram_stat and
// data_out per instance and is compared every cycle; directed literal
// checks pin the model to hand-computed values.
module tb_ram_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] ctrl = '0, addr_v = '0, din = '0;
  logic [31:0] junk = '0;

  always #5 clk = ~clk;

  ram_responder_if bus0 ();
  ram_responder_if bus1 ();
  ram_responder_if bus2 ();

  assign bus0.ram_ctrl = ctrl;  assign bus0.addr = addr_v;  assign bus0.data_in = din;
  assign bus1.ram_ctrl = ctrl;  assign bus1.addr = addr_v;  assign bus1.data_in = din;
  assign bus2.ram_ctrl = ctrl;  assign bus2.addr = addr_v;  assign bus2.data_in = din;

  ram_responder #(.DEPTH(4096), .LATENCY(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ram_responder #(.DEPTH(4096), .LATENCY(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  ram_responder #(.DEPTH(4096), .LATENCY(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [31:0] stat_w [3];
  logic [31:0] dout_w [3];
  assign stat_w[0] = bus0.ram_stat;  assign dout_w[0] = bus0.data_out;
  assign stat_w[1] = bus1.ram_stat;  assign dout_w[1] = bus1.data_out;
  assign stat_w[2] = bus2.ram_stat;  assign dout_w[2] = bus2.data_out;

  int vectors = 0;
  int miscompares = 0;
  int lat_cfg [3] = '{2, 4, 1};

  // ---------------- reference model ----------------
  // m_st: 0 idle, 1 accepted (waiting for ack edge), 2 acked (holding)
  int          cyc = 0;
  int          m_st [3];
  int          m_ack_at [3];
  logic [31:0] m_a [3], m_d [3];
  bit          m_rd [3], m_wr [3];
  bit          m_err;
  logic [31:0] e_stat [3], e_data [3];
  bit          e_dk [3];
  logic [31:0] mmem [3][4096];
  bit          mval [3][4096];
  bit          checking = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        case (m_st[k])
          0: if (ctrl[0] || ctrl[1]) begin
               m_rd[k] = ctrl[0]; m_wr[k] = ctrl[1];
               m_a[k] = addr_v;   m_d[k] = din;
               m_ack_at[k] = cyc + lat_cfg[k];
               m_st[k] = 1;
               e_stat[k] = 32'h2;
             end
          1: if (cyc == m_ack_at[k]) begin
               m_err = (m_rd[k] && m_wr[k]) || (m_a[k] > 32'd4095);
               e_stat[k] = m_err ? 32'h5 : 32'h1;
               e_data[k] = '0;
               e_dk[k]   = 1'b1;
               if (!m_err && m_wr[k]) begin
                 mmem[k][m_a[k][11:0]] = m_d[k];
                 mval[k][m_a[k][11:0]] = 1'b1;
               end else if (!m_err) begin
                 e_data[k] = mmem[k][m_a[k][11:0]];
                 e_dk[k]   = mval[k][m_a[k][11:0]];
               end
               m_st[k] = 2;
             end
          default: if (!(ctrl[0] || ctrl[1])) begin
               e_stat[k] = '0; e_data[k] = '0; e_dk[k] = 1'b1;
               m_st[k] = 0;
             end
        endcase
      end
    end
  end

  always @(negedge rst) begin
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; e_stat[k] = '0; e_data[k] = '0; e_dk[k] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (checking && rst) begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (stat_w[k] !== e_stat[k] || (e_dk[k] && dout_w[k] !== e_data[k])) begin
          miscompares++;
          $display("FAIL model dut%0d cyc %0d: ram_stat=%h data_out=%h, expected ram_stat=%h data_out=%h",
                   k, cyc, stat_w[k], dout_w[k], e_stat[k], e_data[k]);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  logic [31:0] t_stat [3], t_data [3];
  int          t_lat [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 50) begin
      busy = 1'b0;
      for (int k = 0; k < 3; k++) if (stat_w[k] != 32'h0) busy = 1'b1;
      if (busy) begin @(negedge clk); n++; end
    end
    vectors++;
    if (busy) begin
      miscompares++;
      $display("FAIL idle_timeout: got busy expected idle within 50 cycles");
    end
  endtask

  // Issue one request; addr/data_in are scrambled after acceptance to show
  // the latched copies are used. With abort the pins drop one cycle later.
  task automatic txn(input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] d, input bit abort);
    int  n;
    bit  done;
    @(negedge clk);
    ctrl = {junk[31:2], op}; addr_v = a; din = d;
    for (int k = 0; k < 3; k++) begin t_lat[k] = -1; t_stat[k] = '0; t_data[k] = '0; end
    if (abort) begin
      @(negedge clk);
      ctrl = '0; addr_v = $urandom; din = $urandom;
    end else begin
      n = 0; done = 1'b0;
      while (!done && n < 50) begin
        @(negedge clk); n++;
        if (n == 1) begin addr_v = $urandom; din = $urandom; end
        done = 1'b1;
        for (int k = 0; k < 3; k++) begin
          if (t_lat[k] < 0) begin
            if (stat_w[k][0]) begin
              t_lat[k] = n - 1; t_stat[k] = stat_w[k]; t_data[k] = dout_w[k];
            end else done = 1'b0;
          end
        end
      end
      vectors++;
      if (!done) begin
        miscompares++;
        $display("FAIL ack_timeout: got no ACK expected ACK within 50 cycles");
      end
      ctrl = '0;
    end
    wait_idle();
  endtask

  task automatic check_all(input string name, input logic [31:0] es, input logic [31:0] ed);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_stat_dut%0d", name, k), t_stat[k], es);
      chk($sformatf("%s_data_dut%0d", name, k), t_data[k], ed);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    int          r;
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; e_stat[k] = '0; e_data[k] = '0; e_dk[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_stat_dut%0d", k), stat_w[k], 32'h0);
      chk($sformatf("reset_data_dut%0d", k), dout_w[k], 32'h0);
    end
    #1 rst = 1'b1;
    checking = 1'b1;

    // write then read back, latency per instance
    txn(2'b10, 32'd5, 32'h0000_0A5A, 1'b0);
    chk("lat_dut0", 32'(t_lat[0]), 32'd2);
    chk("lat_dut1", 32'(t_lat[1]), 32'd4);
    chk("lat_dut2", 32'(t_lat[2]), 32'd1);
    check_all("wr5", 32'h1, 32'h0);
    txn(2'b01, 32'd5, 32'h0, 1'b0);
    check_all("rd5", 32'h1, 32'h0000_0A5A);
    for (int k = 0; k < 3; k++) chk($sformatf("rd5_after_dut%0d", k), dout_w[k], 32'h0);

    // both pins high: error, no write
    txn(2'b10, 32'd3, 32'h1234_5678, 1'b0);
    txn(2'b11, 32'd3, 32'hFFFF_FFFF, 1'b0);
    check_all("both3", 32'h5, 32'h0);
    txn(2'b01, 32'd3, 32'h0, 1'b0);
    check_all("rd3", 32'h1, 32'h1234_5678);

    // out of range (4096 must not alias onto word 0)
    txn(2'b10, 32'd0, 32'hDEAD_0000, 1'b0);
    txn(2'b10, 32'd4096, 32'h0000_0BAD, 1'b0);
    check_all("wr4096", 32'h5, 32'h0);
    txn(2'b01, 32'd0, 32'h0, 1'b0);
    check_all("rd0", 32'h1, 32'hDEAD_0000);
    txn(2'b01, 32'hFFFF_FFFF, 32'h0, 1'b0);
    check_all("rdmax", 32'h5, 32'h0);
    txn(2'b10, 32'd4095, 32'h0000_CAFE, 1'b0);
    txn(2'b01, 32'd4095, 32'h0, 1'b0);
    check_all("rd4095", 32'h1, 32'h0000_CAFE);

    // abort: write still commits
    txn(2'b10, 32'd7, 32'h0000_0077, 1'b1);
    txn(2'b01, 32'd7, 32'h0, 1'b0);
    check_all("rd7", 32'h1, 32'h0000_0077);

    // asynchronous reset mid-access
    @(negedge clk);
    ctrl = 32'h1; addr_v = 32'd5;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("arst_stat_dut%0d", k), stat_w[k], 32'h0);
      chk($sformatf("arst_data_dut%0d", k), dout_w[k], 32'h0);
    end
    ctrl = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    txn(2'b01, 32'd5, 32'h0, 1'b0);
    check_all("rd5_post_rst", 32'h1, 32'h0000_0A5A);

    // mobo-style loop
    for (int i = 0; i < 20; i++) begin
      txn(2'b10, 32'(i), 32'(i), 1'b0);
      txn(2'b01, 32'(i), 32'h0, 1'b0);
      for (int k = 0; k < 3; k++) chk($sformatf("loop%0d_dut%0d", i, k), t_data[k], 32'(i));
    end

    // randomized traffic, stray upper ctrl bits, occasional aborts
    for (int i = 0; i < 80; i++) begin
      op = 2'($urandom_range(1, 3));
      r  = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'd4095 + 32'($urandom_range(0, 1));
      else             a = 32'($urandom_range(0, 31));
      junk = $urandom;
      txn(op, a, $urandom, ($urandom_range(0, 4) == 0));
    end
    junk = '0;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
